// File: rtl/fee_evt_pkg.sv
// Shared definitions for the FEE event path: framing constants, word classes, packer states,
// trailer field layout and the helpers that classify a FIFO word and build a trailer word.
package fee_evt_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam logic [15:0] EVT_TAG    = 16'hEB90;
    localparam logic [31:0] END_MARKER = 32'hC5D5C5D5;
    localparam logic [3:0]  TRL_TAG    = 4'hF;

    // Channel header sample count
    localparam int unsigned HDR_LEN_LSB = 16;
    localparam int unsigned HDR_LEN_W   = 10;

    // Trailer field positions
    localparam int unsigned TRL_TAG_LSB   = 28;
    localparam int unsigned TRL_ERR_BIT   = 27;
    localparam int unsigned TRL_CHCNT_LSB = 16;
    localparam int unsigned TRL_WCNT_LSB  = 0;

    typedef enum logic [1:0] {WC_HDR, WC_PAY, WC_END, WC_BAD} word_class_e;
    typedef enum logic [1:0] {S_IDLE, S_BODY, S_TRL} state_e;

    // The end marker has bits[31:30]=11, so it must be recognised before the generic 1x case.
    function automatic word_class_e classify(input logic [WORD_W-1:0] w);
        if (w == END_MARKER)       return WC_END;
        else if (w[31:30] == 2'b01) return WC_HDR;
        else if (w[31:30] == 2'b00) return WC_PAY;
        else                        return WC_BAD;
    endfunction

    function automatic logic [WORD_W-1:0] trailer_word(input logic        err,
                                                       input logic [7:0]  chcnt,
                                                       input logic [15:0] wcnt);
        logic [WORD_W-1:0] w;
        w                         = '0;
        w[TRL_TAG_LSB +: 4]       = TRL_TAG;
        w[TRL_ERR_BIT]            = err;
        w[TRL_CHCNT_LSB +: 8]     = chcnt;
        w[TRL_WCNT_LSB +: 16]     = wcnt;
        return w;
    endfunction

endpackage

// File: rtl/dtc_evt_packer_if.sv
// DTC link stream: 32-bit words with valid/ready handshake and start/end-of-event qualifiers.
//   dtc_data  - output word
//   dtc_valid - dtc_data valid
//   dtc_ready - sink accepts the word when dtc_valid && dtc_ready
//   dtc_sop   - qualifies the event header word
//   dtc_eop   - qualifies the trailer word
// master: the packer (source). slave: the link sink.
interface dtc_evt_packer_if;
    import fee_evt_pkg::*;

    logic [WORD_W-1:0] dtc_data;
    logic              dtc_valid;
    logic              dtc_ready;
    logic              dtc_sop;
    logic              dtc_eop;

    modport master (output dtc_data, output dtc_valid, output dtc_sop, output dtc_eop,
                    input dtc_ready);
    modport slave  (input dtc_data, input dtc_valid, input dtc_sop, input dtc_eop,
                    output dtc_ready);

endinterface

// File: rtl/evt_skid2.sv
// Two-entry skid buffer in front of the event FIFO read port (1-cycle read latency).
//   rdoclk, reset - clock, asynchronous active-high reset
//   fifo_q        - FIFO data, valid on the posedge after fifo_rdreq
//   fifo_empty    - FIFO empty
//   fifo_rdreq    - registered pop request to the FIFO
//   pop           - consumer takes the head word this cycle
//   head_valid    - buffer holds at least one word
//   head_data     - oldest buffered word
module evt_skid2
    import fee_evt_pkg::*;
(
    input  logic              rdoclk,
    input  logic              reset,
    input  logic [WORD_W-1:0] fifo_q,
    input  logic              fifo_empty,
    output logic              fifo_rdreq,
    input  logic              pop,
    output logic              head_valid,
    output logic [WORD_W-1:0] head_data
);

    logic [WORD_W-1:0] mem_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        cnt_q, cnt_d;
    logic              rdreq_q, rdreq_d;
    logic              push, do_pop;

    // A request issued last edge returns its word on this edge.
    assign push   = rdreq_q;
    assign do_pop = pop && (cnt_q != 2'd0);
    assign cnt_d  = cnt_q + {1'b0, push} - {1'b0, do_pop};
    // After this edge the request itself is the only read in flight, so it fits iff the
    // post-edge occupancy leaves a free slot for it.
    assign rdreq_d = !fifo_empty && (cnt_d < 2'd2);

    always_ff @(posedge rdoclk or posedge reset) begin
        if (reset) begin
            cnt_q    <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            rdreq_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            rdreq_q <= rdreq_d;
            if (push)   wr_ptr_q <= ~wr_ptr_q;
            if (do_pop) rd_ptr_q <= ~rd_ptr_q;
        end
    end

    always_ff @(posedge rdoclk) begin
        if (push) mem_q[wr_ptr_q] <= fifo_q;
    end

    assign fifo_rdreq = rdreq_q;
    assign head_valid = (cnt_q != 2'd0);
    assign head_data  = mem_q[rd_ptr_q];

endmodule

// File: rtl/dtc_evt_packer.sv
// Pops channel-event FIFO words and frames each event for the DTC link: event header, forwarded
// channel words, trailer. Checks channel payload length and strips the end marker.
//   rdoclk, reset         - clock, asynchronous active-high reset
//   fifo_rdreq/q/empty    - event FIFO read port (1-cycle latency)
//   dtc                   - output stream (master side)
//   evt_done              - 1-cycle pulse when the trailer is accepted
//   len_err               - sticky length error, cleared when the next event header is emitted
//   evt_cnt               - completed events, wraps
module dtc_evt_packer
    import fee_evt_pkg::*;
(
    input  logic              rdoclk,
    input  logic              reset,
    output logic              fifo_rdreq,
    input  logic [WORD_W-1:0] fifo_q,
    input  logic              fifo_empty,
    dtc_evt_packer_if.master  dtc,
    output logic              evt_done,
    output logic              len_err,
    output logic [11:0]       evt_cnt
);

    state_e            state_q, state_d;
    logic              skid_valid, skid_pop;
    logic [WORD_W-1:0] skid_data;
    word_class_e       wclass;
    logic              upd;

    logic [WORD_W-1:0] data_q, data_d;
    logic              valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
    logic              len_err_q, len_err_d, evt_done_q, evt_done_d;
    logic [15:0]       wcnt_q, wcnt_d, wcnt_inc;
    logic [7:0]        chcnt_q, chcnt_d, chcnt_inc;
    logic [HDR_LEN_W-1:0] rem_q, rem_d;
    logic [11:0]       evt_cnt_q, evt_cnt_d;

    evt_skid2 u_skid (
        .rdoclk     (rdoclk),
        .reset      (reset),
        .fifo_q     (fifo_q),
        .fifo_empty (fifo_empty),
        .fifo_rdreq (fifo_rdreq),
        .pop        (skid_pop),
        .head_valid (skid_valid),
        .head_data  (skid_data)
    );

    assign wclass    = classify(skid_data);
    // Output slot may be refilled when empty or being accepted this cycle.
    assign upd       = !valid_q || dtc.dtc_ready;
    assign wcnt_inc  = (wcnt_q == 16'hFFFF) ? wcnt_q : wcnt_q + 16'd1;
    assign chcnt_inc = (chcnt_q == 8'hFF) ? chcnt_q : chcnt_q + 8'd1;

    always_ff @(posedge rdoclk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (upd && skid_valid) state_d = S_BODY;
            S_BODY: if (upd && skid_valid && wclass == WC_END) state_d = S_TRL;
            S_TRL:  if (valid_q && dtc.dtc_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        skid_pop   = 1'b0;
        data_d     = data_q;
        valid_d    = valid_q;
        sop_d      = sop_q;
        eop_d      = eop_q;
        len_err_d  = len_err_q;
        wcnt_d     = wcnt_q;
        chcnt_d    = chcnt_q;
        rem_d      = rem_q;
        evt_cnt_d  = evt_cnt_q;
        evt_done_d = 1'b0;
        if (upd) begin
            valid_d = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
        end
        unique case (state_q)
            S_IDLE: begin
                // Header is emitted on sight of data; the skid word stays for BODY.
                if (upd && skid_valid) begin
                    data_d    = {EVT_TAG, 4'h0, evt_cnt_q};
                    valid_d   = 1'b1;
                    sop_d     = 1'b1;
                    len_err_d = 1'b0;
                    wcnt_d    = '0;
                    chcnt_d   = '0;
                    rem_d     = '0;
                end
            end
            S_BODY: begin
                if (upd && skid_valid) begin
                    skid_pop = 1'b1;
                    unique case (wclass)
                        WC_HDR: begin
                            data_d  = skid_data;
                            valid_d = 1'b1;
                            wcnt_d  = wcnt_inc;
                            chcnt_d = chcnt_inc;
                            rem_d   = skid_data[HDR_LEN_LSB +: HDR_LEN_W];
                            if (rem_q != '0) len_err_d = 1'b1;
                        end
                        WC_PAY: begin
                            data_d  = skid_data;
                            valid_d = 1'b1;
                            wcnt_d  = wcnt_inc;
                            rem_d   = (rem_q > 10'd3) ? rem_q - 10'd3 : '0;
                            if (rem_q == '0) len_err_d = 1'b1;
                        end
                        WC_BAD: begin
                            data_d    = skid_data;
                            valid_d   = 1'b1;
                            wcnt_d    = wcnt_inc;
                            len_err_d = 1'b1;
                        end
                        default: begin
                            // End marker is dropped; the trailer takes its slot and must
                            // already reflect this marker's own length check.
                            len_err_d = len_err_q | (rem_q != '0);
                            data_d    = trailer_word(len_err_q | (rem_q != '0), chcnt_q, wcnt_q);
                            valid_d   = 1'b1;
                            eop_d     = 1'b1;
                        end
                    endcase
                end
            end
            S_TRL: begin
                if (valid_q && dtc.dtc_ready) begin
                    evt_done_d = 1'b1;
                    evt_cnt_d  = evt_cnt_q + 12'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge rdoclk or posedge reset) begin
        if (reset) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            len_err_q  <= 1'b0;
            evt_done_q <= 1'b0;
            wcnt_q     <= '0;
            chcnt_q    <= '0;
            rem_q      <= '0;
            evt_cnt_q  <= '0;
        end else begin
            data_q     <= data_d;
            valid_q    <= valid_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            len_err_q  <= len_err_d;
            evt_done_q <= evt_done_d;
            wcnt_q     <= wcnt_d;
            chcnt_q    <= chcnt_d;
            rem_q      <= rem_d;
            evt_cnt_q  <= evt_cnt_d;
        end
    end

    assign dtc.dtc_data  = data_q;
    assign dtc.dtc_valid = valid_q;
    assign dtc.dtc_sop   = sop_q;
    assign dtc.dtc_eop   = eop_q;
    assign evt_done      = evt_done_q;
    assign len_err       = len_err_q;
    assign evt_cnt       = evt_cnt_q;

endmodule
